// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and pulse-encode one push-button with auto-repeat
module btn_conditioner #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_hold
);
  localparam int DW = $clog2(STABLE_CYCLES);
  localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [DW-1:0] DB_TOP = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_TOP = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_TOP = HW'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = REPEAT_PERIOD != 0;
  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_t;
  state_t state, state_d;
  logic sync_q1, sync;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt, hold_d, hold_inc;
  logic db_top, rise, fall, repeat_d, long_d;
  assign db_top = sync != level && db_cnt == DB_TOP;
  assign rise = db_top && sync;
  assign fall = db_top && !sync;
  assign hold_inc = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
  // two-flop synchroniser feeding a consecutive-sample debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync <= 1'b0;
      db_cnt <= '0;
      level <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync <= sync_q1;
      db_cnt <= (sync == level || db_top) ? '0 : db_cnt + 1'b1;
      level <= db_top ? sync : level;
    end
  end
  // hold FSM: release overrides everything, including a coincident repeat
  always_comb begin
    state_d = state;
    hold_d = hold_cnt;
    repeat_d = 1'b0;
    long_d = long_hold;
    if (fall) begin
      state_d = IDLE;
      hold_d = '0;
      long_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state_d = HOLD_DELAY;
          hold_d = '0;
        end
        HOLD_DELAY: if (hold_cnt != DLY_TOP) hold_d = hold_inc;
          else if (REPEAT_EN) begin
            state_d = HOLD_REPEAT;
            hold_d = '0;
            repeat_d = 1'b1;
            long_d = 1'b1;
          end
        HOLD_REPEAT: if (hold_cnt != PER_TOP) hold_d = hold_inc;
          else begin
            hold_d = '0;
            repeat_d = 1'b1;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  // registered FSM state, hold counter and event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      press <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      long_hold <= 1'b0;
    end else begin
      state <= state_d;
      hold_cnt <= hold_d;
      press <= rise;
      release_pulse <= fall;
      repeat_pulse <= repeat_d;
      long_hold <= long_d;
    end
  end
endmodule
